multimode_counter: RTL and testbench

Parametrised up/down counter with programmable terminal value, wrap or saturate mode, synchronous load and a registered terminal-count pulse. It is the general-purpose successor of the plain enable/clear counter. It serves as a timer, event counter or address generator wherever a simple 0..2^W-1 incrementer is too rigid. An optional prescaler is compiled in to step the counter once every N enabled cycles.

---
 rtl/multimode_counter_pkg.sv | 14 +
 rtl/multimode_counter_prescaler.sv | 49 ++++
 rtl/multimode_counter.sv | 93 +++++++++
 tb/tb_multimode_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multimode_counter_pkg.sv
// Shared encodings and default widths for multimode_counter.
// The prescaler is present only when CNTR_PRESCALE_EN is defined.
package multimode_counter_pkg;

    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    localparam int CNT_DEFAULT_WIDTH   = 8;
    localparam int PRESC_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/multimode_counter_prescaler.sv
// Enabled-cycle prescaler: tick fires once every presc_div+1 cycles with en high.
// Only compiled when CNTR_PRESCALE_EN is defined.
`ifdef CNTR_PRESCALE_EN
module counter_prescaler
    import multimode_counter_pkg::*;
#(
    parameter int PRESC_WIDTH = PRESC_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] phase_q;
    logic [PRESC_WIDTH-1:0] phase_d;
    logic                   at_div;

    // >= rather than == so a presc_div lowered below the current phase
    // terminates the period at once instead of running the phase around.
    assign at_div = (phase_q >= presc_div);

    always_comb begin
        phase_d = phase_q;
        tick    = 1'b0;
        if (clr) begin
            phase_d = '0;
        end else if (en) begin
            if (at_div) begin
                phase_d = '0;
                tick    = 1'b1;
            end else begin
                phase_d = phase_q + PRESC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule
`endif

// File: rtl/multimode_counter.sv
// Up/down counter with programmable limit, wrap/saturate, load and registered tc.
// Define CNTR_PRESCALE_EN to gate steps through counter_prescaler.
module multimode_counter
    import multimode_counter_pkg::*;
#(
    parameter int CNTR_WIDTH  = CNT_DEFAULT_WIDTH,
    parameter int PRESC_WIDTH = PRESC_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   dir,
    input  logic                   load,
    input  logic [CNTR_WIDTH-1:0]  load_val,
    input  logic [CNTR_WIDTH-1:0]  limit,
    input  logic                   sat,
    input  logic [PRESC_WIDTH-1:0] presc_div,
    output logic [CNTR_WIDTH-1:0]  cnt,
    output logic                   tc
);

    logic [CNTR_WIDTH-1:0] cnt_q;
    logic [CNTR_WIDTH-1:0] cnt_d;
    logic                  tc_q;
    logic                  tc_d;
    logic                  tick;
    logic                  step;
    logic                  at_top;
    logic                  at_bottom;

`ifdef CNTR_PRESCALE_EN
    counter_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr | load),
        .en        (en),
        .presc_div (presc_div),
        .tick      (tick)
    );
`else
    logic unused_presc_div;
    assign unused_presc_div = ^presc_div;
    assign tick             = 1'b1;
`endif

    assign step      = en && tick;
    // Compare with >= so a count left above a freshly lowered limit wraps/clamps.
    assign at_top    = (cnt_q >= limit);
    assign at_bottom = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = (load_val > limit) ? limit : load_val;
        end else if (step) begin
            if (dir == CNT_DIR_UP) begin
                if (at_top) begin
                    tc_d  = 1'b1;
                    cnt_d = (sat == CNT_MODE_SAT) ? limit : '0;
                end else begin
                    cnt_d = cnt_q + CNTR_WIDTH'(1);
                end
            end else begin
                if (at_bottom) begin
                    tc_d  = 1'b1;
                    cnt_d = (sat == CNT_MODE_SAT) ? '0 : limit;
                end else begin
                    cnt_d = cnt_q - CNTR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_multimode_counter.sv
// Directed self-checking bench for multimode_counter at W = 4.
// Prescaler cases run only when CNTR_PRESCALE_EN is defined.
module tb_multimode_counter;

    localparam int W  = 4;
    localparam int PW = 4;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic          en;
    logic          dir;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  limit;
    logic          sat;
    logic [PW-1:0] presc_div;
    logic [W-1:0]  cnt;
    logic          tc;

    logic [W:0] exp_q[$];
    int         n_tests;
    int         n_fail;

    multimode_counter #(
        .CNTR_WIDTH  (W),
        .PRESC_WIDTH (PW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .limit     (limit),
        .sat       (sat),
        .presc_div (presc_div),
        .cnt       (cnt),
        .tc        (tc)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: queue the expected {tc,cnt}, clock once, compare away from the edge.
    task automatic cycle(input string tag, input logic [W-1:0] e_cnt, input logic e_tc);
        logic [W:0] e;
        exp_q.push_back({e_tc, e_cnt});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {27'd0, tc, cnt}, {27'd0, e});
    endtask

    task automatic set_mode(input logic [W-1:0] lim, input logic s, input logic d);
        limit = lim;
        sat   = s;
        dir   = d;
    endtask

    task automatic do_load(input logic [W-1:0] v, input logic [W-1:0] e_cnt);
        load     = 1'b1;
        load_val = v;
        cycle("load", e_cnt, 1'b0);
        load     = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cycle("clr", 4'd0, 1'b0);
        clr = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        dir       = 1'b1;
        load      = 1'b0;
        load_val  = '0;
        limit     = 4'd9;
        sat       = 1'b0;
        presc_div = '0;
        #12;
        check("reset_cnt", {28'd0, cnt}, 32'd0);
        check("reset_tc", {31'd0, tc}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Count up to 7, then reset asynchronously mid-cycle.
        set_mode(4'd9, 1'b0, 1'b1);
        en = 1'b1;
        for (int i = 1; i <= 7; i++) cycle("pre_reset_up", 4'(i), 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_cnt", {28'd0, cnt}, 32'd0);
        check("async_reset_tc", {31'd0, tc}, 32'd0);
        cycle("in_reset_hold", 4'd0, 1'b0);
        rst_n = 1'b1;
        en    = 1'b0;
        cycle("post_reset_idle", 4'd0, 1'b0);
        cycle("post_reset_idle2", 4'd0, 1'b0);

        // Up wrap over limit 9: 1..9, 0 with tc, twice.
        en = 1'b1;
        for (int k = 1; k <= 20; k++) cycle("up_wrap", 4'(k % 10), (k % 10) == 0);
        en = 1'b0;
        cycle("en_low_hold", 4'd0, 1'b0);

        // Down saturate from 2 at limit 12.
        set_mode(4'd12, 1'b1, 1'b0);
        do_load(4'd2, 4'd2);
        en = 1'b1;
        cycle("down_sat_1", 4'd1, 1'b0);
        cycle("down_sat_0", 4'd0, 1'b0);
        cycle("down_sat_hold_a", 4'd0, 1'b1);
        cycle("down_sat_hold_b", 4'd0, 1'b1);
        en = 1'b0;
        cycle("down_sat_stop", 4'd0, 1'b0);

        // Priority: clr beats load and step; then load clamps to limit.
        set_mode(4'd12, 1'b0, 1'b1);
        do_load(4'd7, 4'd7);
        clr      = 1'b1;
        load     = 1'b1;
        load_val = 4'd5;
        en       = 1'b1;
        cycle("clr_over_load", 4'd0, 1'b0);
        clr      = 1'b0;
        load_val = 4'd15;
        limit    = 4'd10;
        cycle("load_clamp", 4'd10, 1'b0);
        load     = 1'b0;
        en       = 1'b0;
        do_load(4'd4, 4'd4);
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd8;
        cycle("load_over_step", 4'd8, 1'b0);
        load = 1'b0;
        en   = 1'b0;

        // Limit lowered below count: wrap then saturate.
        set_mode(4'd15, 1'b0, 1'b1);
        do_load(4'd12, 4'd12);
        limit = 4'd5;
        en    = 1'b1;
        cycle("lowered_wrap", 4'd0, 1'b1);
        en = 1'b0;
        limit = 4'd15;
        do_load(4'd12, 4'd12);
        set_mode(4'd5, 1'b1, 1'b1);
        en = 1'b1;
        cycle("lowered_sat", 4'd5, 1'b1);
        cycle("sat_top_hold", 4'd5, 1'b1);
        en = 1'b0;
        cycle("tc_drops", 4'd5, 1'b0);

        // Down wrap reloads limit; limit 0 pins count at 0 with tc.
        do_clr();
        set_mode(4'd3, 1'b0, 1'b0);
        en = 1'b1;
        cycle("down_wrap", 4'd3, 1'b1);
        cycle("down_step", 4'd2, 1'b0);
        en = 1'b0;
        do_clr();
        set_mode(4'd0, 1'b0, 1'b1);
        en = 1'b1;
        cycle("lim0_up", 4'd0, 1'b1);
        dir = 1'b0;
        cycle("lim0_down", 4'd0, 1'b1);
        sat = 1'b1;
        cycle("lim0_down_sat", 4'd0, 1'b1);
        en = 1'b0;

`ifdef CNTR_PRESCALE_EN
        // presc_div = 2: one step every third enabled cycle.
        do_clr();
        set_mode(4'd15, 1'b0, 1'b1);
        presc_div = 4'd2;
        en        = 1'b1;
        cycle("presc_a", 4'd0, 1'b0);
        cycle("presc_b", 4'd0, 1'b0);
        cycle("presc_c", 4'd1, 1'b0);
        cycle("presc_d", 4'd1, 1'b0);
        cycle("presc_e", 4'd1, 1'b0);
        cycle("presc_f", 4'd2, 1'b0);
        cycle("presc_g", 4'd2, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) cycle("presc_frozen", 4'd2, 1'b0);
        en = 1'b1;
        cycle("presc_resume_a", 4'd2, 1'b0);
        cycle("presc_resume_b", 4'd3, 1'b0);
        cycle("presc_mid", 4'd3, 1'b0);
        en = 1'b0;
        do_load(4'd5, 4'd5);
        en = 1'b1;
        cycle("presc_reload_a", 4'd5, 1'b0);
        cycle("presc_reload_b", 4'd5, 1'b0);
        cycle("presc_reload_c", 4'd6, 1'b0);
        presc_div = 4'd0;
        cycle("presc_div0_a", 4'd7, 1'b0);
        cycle("presc_div0_b", 4'd8, 1'b0);
        en = 1'b0;
`else
        // Without the prescaler, presc_div has no effect.
        do_clr();
        set_mode(4'd15, 1'b0, 1'b1);
        presc_div = 4'd2;
        en        = 1'b1;
        cycle("no_presc_a", 4'd1, 1'b0);
        cycle("no_presc_b", 4'd2, 1'b0);
        cycle("no_presc_c", 4'd3, 1'b0);
        en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
